// File: rtl/row_clear.sv
// ---------------------------------------------------------------------------
// row_clear -- line-clear engine for the playfield grid.
//
// Takes the grid captured on an accepted start, removes every full row by
// collapsing the rows above it downwards, and reports the compacted grid
// together with the number of rows removed. Exactly one row is examined per
// clock so the next-grid logic stays short.
//
// Optional feature macro: ROW_CLEAR_SCORE_EN
//   defined   -> score accumulates a weighted count of cleared rows
//                (saturating, cleared only by clr)
//   undefined -> score is tied to zero and no accumulator exists
//
// Ports:
//   clk       system clock
//   clr       synchronous active-low reset
//   start     single-cycle request to process grid_in (only while idle)
//   grid_in   grid to process, bit = row*COLS+col, row 0 top, col 0 left
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse, grid_out/lines valid in that cycle
//   grid_out  compacted grid, held until the next done
//   lines     rows removed in the last pass, held until the next done
//   score     running weighted total of cleared rows (optional feature)
// ---------------------------------------------------------------------------
module row_clear #(
   parameter int ROWS    = 20,
   parameter int COLS    = 10,
   parameter int CNT_W   = 5,
   parameter int SCORE_W = 16
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] grid_in,
   output logic                 busy,
   output logic                 done,
   output logic [ROWS*COLS-1:0] grid_out,
   output logic [CNT_W-1:0]     lines,
   output logic [SCORE_W-1:0]   score
);

   localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state;
   logic [ROWS*COLS-1:0]   work;
   logic [PTR_W-1:0]       row_ptr;
   logic [CNT_W-1:0]       count;

   logic [COLS-1:0]        cur_row;
   logic                   row_full;
   logic                   scan_end;
   logic [ROWS*COLS-1:0]   shifted;

   // Select the row under the pointer and decide whether it is full. When
   // it is, build the collapsed grid: every row at or above the pointer
   // takes the row above it and the top row is refilled with zeros. Rows
   // below the pointer are already final and stay untouched.
   always_comb begin
      cur_row = '0;
      shifted = work;
      for (int i = 0; i < ROWS; i++) begin
         if (PTR_W'(i) == row_ptr) begin
            cur_row = work[i*COLS +: COLS];
         end
         if (i == 0) begin
            shifted[0 +: COLS] = '0;
         end else if (PTR_W'(i) <= row_ptr) begin
            shifted[i*COLS +: COLS] = work[(i-1)*COLS +: COLS];
         end
      end
      row_full = &cur_row;
      scan_end = (state == SCAN) && !row_full && (row_ptr == '0);
   end

   // Main controller. The pointer stays put after a clear so the row that
   // just dropped into place is examined on the next cycle. Results and
   // done are loaded on the edge that enters DONE, so they are visible in
   // the same cycle the FSM sits in DONE; start is not looked at there.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= IDLE;
         work     <= '0;
         row_ptr  <= LAST_ROW;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         grid_out <= '0;
         lines    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work    <= grid_in;
                  row_ptr <= LAST_ROW;
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= SCAN;
               end
            end
            SCAN: begin
               if (row_full) begin
                  work  <= shifted;
                  count <= count + CNT_W'(1);
               end else if (row_ptr != '0) begin
                  row_ptr <= row_ptr - PTR_W'(1);
               end else begin
                  grid_out <= work;
                  lines    <= count;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ROW_CLEAR_SCORE_EN
   logic [CNT_W:0]   weight;
   logic [SCORE_W:0] score_sum;
   logic [SCORE_W-1:0] score_q;

   // Multi-row clears are rewarded more than the same rows cleared one at
   // a time; beyond four rows each extra row is worth one more point.
   always_comb begin
      case (count)
         CNT_W'(0): weight = (CNT_W+1)'(0);
         CNT_W'(1): weight = (CNT_W+1)'(1);
         CNT_W'(2): weight = (CNT_W+1)'(3);
         CNT_W'(3): weight = (CNT_W+1)'(5);
         CNT_W'(4): weight = (CNT_W+1)'(8);
         default:   weight = {1'b0, count} + (CNT_W+1)'(4);
      endcase
      score_sum = {1'b0, score_q} + (SCORE_W+1)'(weight);
   end

   // Accumulate on the same edge that publishes lines, saturating rather
   // than wrapping; only clr brings the total back to zero.
   always_ff @(posedge clk) begin
      if (!clr) begin
         score_q <= '0;
      end else if (scan_end) begin
         if (score_sum[SCORE_W]) begin
            score_q <= '1;
         end else begin
            score_q <= score_sum[SCORE_W-1:0];
         end
      end
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_row_clear.sv
// ---------------------------------------------------------------------------
// tb_row_clear -- directed self-checking bench for row_clear.
// Each pass is started, timed from the accepting edge, and its result,
// busy window and done-pulse count are compared against hand-built grids.
// ---------------------------------------------------------------------------
module tb_row_clear;

   localparam int ROWS    = 20;
   localparam int COLS    = 10;
   localparam int CNT_W   = 5;
   localparam int SCORE_W = 16;
   localparam int W       = ROWS * COLS;

   logic               clk;
   logic               clr;
   logic               start;
   logic [W-1:0]       grid_in;
   logic               busy;
   logic               done;
   logic [W-1:0]       grid_out;
   logic [CNT_W-1:0]   lines;
   logic [SCORE_W-1:0] score;

   int checks;
   int errors;
   logic [SCORE_W-1:0] exp_score;

   row_clear #(
      .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk),
      .clr(clr),
      .start(start),
      .grid_in(grid_in),
      .busy(busy),
      .done(done),
      .grid_out(grid_out),
      .lines(lines),
      .score(score)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] with_row(input logic [W-1:0] g,
                                             input int r,
                                             input logic [COLS-1:0] v);
      logic [W-1:0] t;
      t = g;
      t[r*COLS +: COLS] = v;
      return t;
   endfunction

   function automatic int weight_of(input int l);
      case (l)
         0:       return 0;
         1:       return 1;
         2:       return 3;
         3:       return 5;
         4:       return 8;
         default: return l + 4;
      endcase
   endfunction

   // Run one complete pass. The cycle count is 0 in the start cycle, so
   // the first sample after the accepting edge is cycle 1. Optionally a
   // competing start with a different grid is raised mid-pass.
   task automatic applyStimulus(input string tag, input logic [W-1:0] g,
                                input logic [W-1:0] exp_grid,
                                input int exp_lines, input int exp_cycle,
                                input bit inject);
      int cyc;
      int busy_cycles;
      int extra_done;
      @(posedge clk); #1;
      grid_in = g;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      grid_in = '0;
      cyc         = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy === 1'b1) busy_cycles++;
         if (inject && cyc == 5) begin
            grid_in = '1;
            start   = 1'b1;
         end
         if (inject && cyc == 6) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
`ifdef ROW_CLEAR_SCORE_EN
      exp_score = exp_score + SCORE_W'(weight_of(exp_lines));
`endif
      checkOutput({tag, "_done_cycle"}, W'(cyc), W'(exp_cycle));
      checkOutput({tag, "_busy_cycles"}, W'(busy_cycles), W'(exp_cycle - 1));
      checkOutput({tag, "_busy_at_done"}, W'(busy), W'(0));
      checkOutput({tag, "_lines"}, W'(lines), W'(exp_lines));
      checkOutput({tag, "_grid"}, grid_out, exp_grid);
      checkOutput({tag, "_score"}, W'(score), W'(exp_score));
      extra_done = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra_done++;
      end
      checkOutput({tag, "_extra_done"}, W'(extra_done), W'(0));
      checkOutput({tag, "_lines_held"}, W'(lines), W'(exp_lines));
   endtask

   initial begin
      logic [W-1:0] g2;
      logic [W-1:0] e2;
      logic [W-1:0] g3;
      logic [W-1:0] e3;
      logic [W-1:0] ga;
      int extra_done;

      checks    = 0;
      errors    = 0;
      exp_score = '0;
      clr       = 1'b0;
      start     = 1'b0;
      grid_in   = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", W'(busy), W'(0));
      checkOutput("reset_done", W'(done), W'(0));
      checkOutput("reset_grid", grid_out, '0);
      checkOutput("reset_lines", W'(lines), W'(0));
      checkOutput("reset_score", W'(score), W'(0));
      clr = 1'b1;

      g2 = with_row(with_row('0, 19, 10'b1111111111), 18, 10'b0000000001);
      e2 = with_row('0, 19, 10'b0000000001);

      g3 = with_row('0, 19, 10'b1111111111);
      g3 = with_row(g3, 18, 10'b1010101010);
      g3 = with_row(g3, 17, 10'b1111111111);
      g3 = with_row(g3, 16, 10'b0000011111);
      e3 = with_row('0, 19, 10'b1010101010);
      e3 = with_row(e3, 18, 10'b0000011111);

      applyStimulus("empty", '0, '0, 0, 21, 1'b0);
      applyStimulus("one_row", g2, e2, 1, 22, 1'b0);
      applyStimulus("two_rows", g3, e3, 2, 23, 1'b0);
      applyStimulus("all_full", '1, '0, 20, 41, 1'b0);
      applyStimulus("start_ignored", g2, e2, 1, 22, 1'b1);

      // Abort a pass at cycle 10 with reset and a simultaneous start.
      ga = with_row('0, 19, 10'b1111111111);
      @(posedge clk); #1;
      grid_in = ga;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_busy_before", W'(busy), W'(1));
      clr   = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_busy", W'(busy), W'(0));
      checkOutput("abort_done", W'(done), W'(0));
      checkOutput("abort_grid", grid_out, '0);
      checkOutput("abort_lines", W'(lines), W'(0));
      checkOutput("abort_score", W'(score), W'(0));
      clr       = 1'b1;
      start     = 1'b0;
      exp_score = '0;
      extra_done = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra_done++;
      end
      checkOutput("abort_no_done", W'(extra_done), W'(0));
      checkOutput("abort_idle_busy", W'(busy), W'(0));

      applyStimulus("after_abort", g2, e2, 1, 22, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
